skolem_sweep_checker: RTL and testbench
=======================================

SKOLEM_SWEEP_CHECKER -- requirements
Module: skolem_sweep_checker

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles per vector before the vector is declared failed.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  begin a full sweep; sampled only in IDLE.
REQ-005 SHALL have port x_out  out  3  universal-input vector {x2,x1,x0} driven to the Skolem function under test.
REQ-006 SHALL have port x_valid  out  1  one-cycle strobe marking a new x_out.
REQ-007 SHALL have port y_in  in  3  Skolem outputs {y2,y1,y0} returned by the function under test.
REQ-008 SHALL have port y_valid  in  1  y_in is valid; honoured only in WAIT.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 SHALL have port done  out  1  one-cycle pulse at sweep completion.
REQ-011 SHALL have port pass  out  1  1 when the last completed sweep had zero failures.
REQ-012 SHALL have port fail_count  out  4  number of failing vectors in the current or last sweep (0..8).
REQ-013 SHALL have port first_fail_x  out  3  x_out of the first failing vector; first_fail_valid  out  1  qualifies it.
REQ-014 SHALL have port timeout_seen  out  1  at least one vector in the sweep failed by timeout.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-016 IDLE: start=1 SHALL clear fail_count, first_fail_valid, first_fail_x, timeout_seen and pass; set x_out=0; go to DRIVE. start in any other state SHALL be ignored.
REQ-017 DRIVE: x_valid SHALL be 1 for exactly this cycle; clear wait counter; go to WAIT.
REQ-018 WAIT: y_valid=1 SHALL register y_in and go to CHECK; otherwise, once the wait counter equals TIMEOUT, go to CHECK with the vector marked timed-out; otherwise increment the wait counter.
REQ-019 CHECK SHALL evaluate phi = ~(x0^x1^x2^y0^y1^y2) on x_out and the registered y; phi=0 or timed-out SHALL count as a failure.
REQ-020 On failure: fail_count SHALL increment by 1; if first_fail_valid=0, capture x_out into first_fail_x and set first_fail_valid; timed-out SHALL set timeout_seen.
REQ-021 CHECK with x_out=7 SHALL go to DONE; otherwise x_out SHALL increment by 1 (no wrap within a sweep) and go to DRIVE.
REQ-022 DONE: done=1 for one cycle; pass SHALL be set to (fail_count==0) including any CHECK-cycle increment; go to IDLE.
REQ-023 pass, fail_count, first_fail_x, first_fail_valid and timeout_seen SHALL hold after DONE until the next accepted start.
REQ-024 Latency: with y_valid high on the first WAIT cycle, each vector SHALL take 3 cycles and done SHALL assert 25 cycles after the start-sampling edge.
REQ-025 y_valid during IDLE, DRIVE, CHECK or DONE SHALL be ignored; y_valid held constantly high SHALL be accepted on the first WAIT cycle.
REQ-026 y_valid on the same cycle the counter reaches TIMEOUT SHALL be accepted as a response, not a timeout.
REQ-027 x_out SHALL stay stable from DRIVE until the following CHECK completes.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, x_out=0, x_valid=0, busy=0, done=0, pass=0, fail_count=0, first_fail_x=0, first_fail_valid=0, timeout_seen=0, wait counter=0.
REQ-029 Reset mid-sweep SHALL abort with no done pulse; the next sweep SHALL require a fresh start.

Verification
REQ-030 Responder y=x, y_valid one cycle after x_valid -> done at cycle 25, pass=1, fail_count=0, first_fail_valid=0, timeout_seen=0.
REQ-031 Responder y=0 -> failures at x=1,2,4,7; fail_count=4, first_fail_x=1, pass=0, timeout_seen=0.
REQ-032 y_valid never asserted, TIMEOUT=15 -> fail_count=8, first_fail_x=0, timeout_seen=1, pass=0, done after 8x(1+16+1)+1 cycles.
REQ-033 y_valid tied high, y=x -> pass=1, done at cycle 25; start pulses during busy produce no restart.
REQ-034 rst_n low during WAIT of x=3 -> all outputs at reset values asynchronously, no done; a new start gives a full 8-vector sweep from x=0.

Source files
------------

// File: rtl/skolem_sweep_checker.sv
// skolem_sweep_checker: sweeps all eight universal inputs x through a Skolem
// function under test and checks phi = ~(x0^x1^x2^y0^y1^y2) on every response.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a sweep (sampled only in IDLE)
//   x_out, x_valid      vector driven to the function, one-cycle strobe
//   y_in, y_valid       response from the function (honoured only in WAIT)
//   busy, done          not-IDLE flag, one-cycle completion pulse
//   pass                last completed sweep had zero failures
//   fail_count          failing vectors in the current/last sweep
//   first_fail_x/valid  first failing vector and its qualifier
//   timeout_seen        at least one vector failed by timeout
module skolem_sweep_checker #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [2:0] x_out,
    output logic       x_valid,
    input  logic [2:0] y_in,
    input  logic       y_valid,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic [2:0] first_fail_x,
    output logic       first_fail_valid,
    output logic       timeout_seen
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    y_reg;
    logic          tmo;
    logic          fail;

    // phi is false exactly when the six-bit parity is odd
    assign fail = tmo | (^{x_out, y_reg});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            x_out            <= '0;
            x_valid          <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_count       <= '0;
            first_fail_x     <= '0;
            first_fail_valid <= 1'b0;
            timeout_seen     <= 1'b0;
            cnt              <= '0;
            y_reg            <= '0;
            tmo              <= 1'b0;
        end else begin
            x_valid <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    fail_count       <= '0;
                    first_fail_valid <= 1'b0;
                    first_fail_x     <= '0;
                    timeout_seen     <= 1'b0;
                    pass             <= 1'b0;
                    x_out            <= '0;
                    x_valid          <= 1'b1;
                    busy             <= 1'b1;
                    state            <= DRIVE;
                end
                DRIVE: begin
                    cnt   <= '0;
                    tmo   <= 1'b0;
                    state <= WAIT;
                end
                // a response arriving on the last counted cycle wins over the timeout
                WAIT: if (y_valid) begin
                    y_reg <= y_in;
                    state <= CHECK;
                end else if (cnt == CW'(TIMEOUT)) begin
                    tmo   <= 1'b1;
                    state <= CHECK;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                CHECK: begin
                    if (fail) begin
                        fail_count <= fail_count + 4'd1;
                        if (!first_fail_valid) begin
                            first_fail_x     <= x_out;
                            first_fail_valid <= 1'b1;
                        end
                        if (tmo) timeout_seen <= 1'b1;
                    end
                    if (x_out == 3'd7) begin
                        // includes this cycle's failure, which has not landed in fail_count yet
                        pass  <= (fail_count == 4'd0) && !fail;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        x_out   <= x_out + 3'd1;
                        x_valid <= 1'b1;
                        state   <= DRIVE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_skolem_sweep_checker.sv
// tb_skolem_sweep_checker: scoreboard bench for skolem_sweep_checker.
module tb_skolem_sweep_checker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] x_out;
    logic       x_valid;
    logic [2:0] y_in = '0;
    logic       y_valid = 1'b0;
    logic       busy, done, pass, first_fail_valid, timeout_seen;
    logic [3:0] fail_count;
    logic [2:0] first_fail_x;

    skolem_sweep_checker #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_out(x_out), .x_valid(x_valid), .y_in(y_in), .y_valid(y_valid),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_x(first_fail_x), .first_fail_valid(first_fail_valid),
        .timeout_seen(timeout_seen)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        p;
        logic [3:0]  fc;
        logic [2:0]  ffx;
        logic        ffv;
        logic        tmo;
        logic [15:0] lat;
    } exp_t;

    logic [2:0] xq[$];
    exp_t       dq[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int mode = 0;
    int k = 0;
    bit seen_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    // responder: modes 0/1 answer one cycle after x_valid (y=x / y=0), 2 never answers,
    // 3 holds y_valid high, 4 answers exactly on the TIMEOUT count
    always @(posedge clk) begin
        #1;
        k = x_valid ? 0 : k + 1;
        y_in = (mode == 1) ? 3'd0 : x_out;
        y_valid = (mode == 3) || ((mode == 0 || mode == 1) && k == 1) || (mode == 4 && k == 16);
    end

    // monitor: pops the scoreboard whenever the DUT strobes x_valid or done
    always @(posedge clk) begin
        #1;
        if (x_valid) begin
            if (xq.size() == 0) chk("unexpected_x_valid", {29'd0, x_out}, 32'hdead);
            else chk("x_out", {29'd0, x_out}, {29'd0, xq.pop_front()});
        end
        if (done) begin
            seen_done = 1;
            if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = dq.pop_front();
                chk("done_flags", {22'd0, pass, fail_count, first_fail_x, first_fail_valid, timeout_seen},
                    {22'd0, e.p, e.fc, e.ffx, e.ffv, e.tmo});
                chk("done_latency", cyc - start_cyc + 1, {16'd0, e.lat});
            end
        end
    end

    function automatic exp_t mk(input logic p, input logic [3:0] fc, input logic [2:0] ffx,
                                input logic ffv, input logic tmo, input logic [15:0] lat);
        exp_t e;
        e.p = p; e.fc = fc; e.ffx = ffx; e.ffv = ffv; e.tmo = tmo; e.lat = lat;
        return e;
    endfunction

    task automatic sweep(input int m, input exp_t e, input bit pulses);
        mode = m;
        seen_done = 0;
        for (int i = 0; i < 8; i++) xq.push_back(3'(i));
        dq.push_back(e);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start_cyc = cyc; start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if (seen_done) break;
            start = pulses && (i == 3 || i == 10 || i == 22);
        end
        start = 1'b0;
        if (!seen_done) chk("done_seen", 32'd0, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("hold_after_done", {22'd0, pass, fail_count, first_fail_x, first_fail_valid, timeout_seen},
            {22'd0, e.p, e.fc, e.ffx, e.ffv, e.tmo});
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("xq_drained", xq.size(), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {18'd0, x_out, x_valid, busy, done, pass, fail_count, first_fail_x, first_fail_valid, timeout_seen}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        sweep(0, mk(1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 16'd25), 1'b0);
        sweep(1, mk(1'b0, 4'd4, 3'd1, 1'b1, 1'b0, 16'd25), 1'b0);
        sweep(2, mk(1'b0, 4'd8, 3'd0, 1'b1, 1'b1, 16'd145), 1'b0);
        sweep(3, mk(1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 16'd25), 1'b1);
        sweep(4, mk(1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 16'd145), 1'b0);

        // abort during WAIT of x=3
        mode = 0;
        for (int i = 0; i < 4; i++) xq.push_back(3'(i));
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        begin
            bit hit = 0;
            for (int i = 0; i < 60 && !hit; i++) begin
                @(posedge clk); #1;
                hit = x_valid && x_out == 3'd3;
            end
            if (!hit) chk("reach_x3", 32'd0, 32'd1);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {18'd0, x_out, x_valid, busy, done, pass, fail_count, first_fail_x, first_fail_valid, timeout_seen}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("no_restart_after_reset", {31'd0, busy}, 32'd0);
        chk("abort_xq_drained", xq.size(), 32'd0);

        sweep(0, mk(1'b1, 4'd0, 3'd0, 1'b0, 1'b0, 16'd25), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
